// File: rtl/n64_sdram_arbiter_pkg.sv
// Shared types and constants for the N64 / DMA SDRAM arbiter.
package sc64;

    // Widest byte address a pending slot can hold (64 MiB SDRAM).
    localparam int CMD_ADDR_W = 26;

    // Bit positions inside the overrun vector.
    localparam int ARB_ID_N64 = 0;
    localparam int ARB_ID_DMA = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_N64 = 2'd1,
        GRANT_DMA = 2'd2
    } e_arb_state;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] address;
        logic [15:0]           wdata;
        logic [1:0]            wmask;
    } mem_cmd_t;

endpackage

// File: rtl/n64_arb_slot.sv
// One-deep pending command latch for a single requester, with sticky
// overrun detection when a new pulse arrives while the slot is occupied.
module n64_arb_slot
    import sc64::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     req,
    input  mem_cmd_t req_cmd,
    input  logic     grant,
    output logic     pending,
    output mem_cmd_t cmd,
    output logic     overrun
);

    // Load on a pulse into an empty slot, free on grant, flag pulses that hit an occupied slot.
    // A grant only happens while pending is set, so it never coincides with a load.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending <= 1'b0;
            cmd     <= '0;
            overrun <= 1'b0;
        end else begin
            if (req && !pending) begin
                pending <= 1'b1;
                cmd     <= req_cmd;
            end else if (grant) begin
                pending <= 1'b0;
            end
            if (req && pending) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/n64_sdram_arbiter.sv
// Arbitrates the single SDRAM command port between the N64 PI path and the
// cartridge DMA engine. N64 wins by default; after STARVE_LIMIT consecutive
// N64 grants with DMA waiting, DMA is forced through.
//
// Handshake: a requester raises x_req for exactly one cycle with its command
// fields valid in that same cycle; the command is latched into a one-deep
// slot and x_ack pulses for one cycle when memory has completed it (x_rdata
// valid with that pulse for reads). Toward memory, mem_req and the mem_*
// fields stay high/stable from grant until the cycle mem_ack is seen; mem_req
// drops in the following cycle and mem_ack outside a transaction is ignored.
module n64_sdram_arbiter
    import sc64::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 26
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              n64_req,
    input  logic              n64_write,
    input  logic [ADDR_W-1:0] n64_address,
    input  logic [15:0]       n64_wdata,
    input  logic [1:0]        n64_wmask,
    output logic              n64_ack,
    output logic [15:0]       n64_rdata,

    input  logic              dma_req,
    input  logic              dma_write,
    input  logic [ADDR_W-1:0] dma_address,
    input  logic [15:0]       dma_wdata,
    input  logic [1:0]        dma_wmask,
    output logic              dma_ack,
    output logic [15:0]       dma_rdata,

    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_wmask,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,

    output logic [1:0]        overrun,

    output e_arb_state        debug_state,
    output logic [3:0]        debug_starve_cnt
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    e_arb_state state, state_next;
    mem_cmd_t   n64_cmd_in, dma_cmd_in;
    mem_cmd_t   n64_cmd, dma_cmd, sel_cmd;
    logic       n64_pending, dma_pending;
    logic       grant_n64, grant_dma;
    logic [3:0] starve_cnt;

    assign n64_cmd_in.write   = n64_write;
    assign n64_cmd_in.address = CMD_ADDR_W'(n64_address);
    assign n64_cmd_in.wdata   = n64_wdata;
    assign n64_cmd_in.wmask   = n64_wmask;

    assign dma_cmd_in.write   = dma_write;
    assign dma_cmd_in.address = CMD_ADDR_W'(dma_address);
    assign dma_cmd_in.wdata   = dma_wdata;
    assign dma_cmd_in.wmask   = dma_wmask;

    n64_arb_slot u_slot_n64 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (n64_req),
        .req_cmd (n64_cmd_in),
        .grant   (grant_n64),
        .pending (n64_pending),
        .cmd     (n64_cmd),
        .overrun (overrun[ARB_ID_N64])
    );

    n64_arb_slot u_slot_dma (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (dma_req),
        .req_cmd (dma_cmd_in),
        .grant   (grant_dma),
        .pending (dma_pending),
        .cmd     (dma_cmd),
        .overrun (overrun[ARB_ID_DMA])
    );

    assign sel_cmd          = grant_dma ? dma_cmd : n64_cmd;
    assign debug_state      = state;
    assign debug_starve_cnt = starve_cnt;

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant decision in IDLE (DMA when starved or alone), return to IDLE on mem_ack.
    always_comb begin
        state_next = state;
        grant_n64  = 1'b0;
        grant_dma  = 1'b0;
        case (state)
            IDLE: begin
                if (dma_pending && (starve_cnt == STARVE_MAX || !n64_pending)) begin
                    grant_dma  = 1'b1;
                    state_next = GRANT_DMA;
                end else if (n64_pending) begin
                    grant_n64  = 1'b1;
                    state_next = GRANT_N64;
                end
            end
            GRANT_N64, GRANT_DMA: begin
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory command registers, per-requester ack pulses and read-data capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_req     <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
            n64_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            n64_rdata   <= '0;
            dma_rdata   <= '0;
        end else begin
            n64_ack <= 1'b0;
            dma_ack <= 1'b0;
            if (grant_n64 || grant_dma) begin
                mem_req     <= 1'b1;
                mem_write   <= sel_cmd.write;
                mem_address <= sel_cmd.address[ADDR_W-1:0];
                mem_wdata   <= sel_cmd.wdata;
                mem_wmask   <= sel_cmd.wmask;
            end else if (state != IDLE && mem_ack) begin
                mem_req <= 1'b0;
                if (state == GRANT_N64) begin
                    n64_ack <= 1'b1;
                    if (!mem_write) begin
                        n64_rdata <= mem_rdata;
                    end
                end else begin
                    dma_ack <= 1'b1;
                    if (!mem_write) begin
                        dma_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    // Count N64 grants that overtook a waiting DMA command; any DMA grant or idle DMA slot resets it.
    always_ff @(posedge clk) begin
        if (!reset_n || !dma_pending || grant_dma) begin
            starve_cnt <= 4'd0;
        end else if (grant_n64 && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: doc/n64_sdram_arbiter.md
# n64_sdram_arbiter

Two-requester arbiter sharing the single SDRAM device port between the N64 PI bus path and the cartridge-side DMA engine. Each requester issues one-cycle command pulses that are latched into a per-requester pending slot. The arbiter grants one slot at a time to memory_sdram and returns a registered acknowledge with read data. N64 has fixed priority for PI latency, with a starvation limit guaranteeing DMA progress.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive N64 grants allowed while DMA is pending before DMA is forced; range 1..15.
- ADDR_W, 26: byte address width (64 MiB SDRAM).

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  synchronous, active-low reset.
- n64_req  in  1  one-cycle command pulse from the N64 path.
- n64_write  in  1  1 = write, 0 = read; sampled with n64_req.
- n64_address  in  ADDR_W  byte address; bit 0 ignored (16-bit access).
- n64_wdata  in  16  write data.
- n64_wmask  in  2  byte enables, [1] = upper byte.
- n64_ack  out  1  one-cycle completion pulse.
- n64_rdata  out  16  read data, valid with n64_ack.
- dma_req, dma_write, dma_address, dma_wdata, dma_wmask, dma_ack, dma_rdata: same as the n64_* ports, for the DMA requester.
- mem_req  out  1  held high until mem_ack.
- mem_write  out  1  command direction.
- mem_address  out  ADDR_W  command address.
- mem_wdata  out  16  write data.
- mem_wmask  out  2  byte enables.
- mem_ack  in  1  one-cycle completion from memory_sdram.
- mem_rdata  in  16  read data, valid with mem_ack.
- overrun  out  2  sticky protocol error per requester, [0] = N64, [1] = DMA.

## Operation
- Pending slot, per requester: req pulse while the slot is empty loads write/address/wdata/wmask and sets pending. Slot clears when granted. Req pulse while pending or granted is ignored and sets the matching overrun bit.
- States:
  - IDLE: no transaction in flight.
  - GRANT_N64: N64 transaction in flight.
  - GRANT_DMA: DMA transaction in flight.
- IDLE transitions:
  - DMA pending and (starve_cnt == STARVE_LIMIT or N64 not pending) -> GRANT_DMA.
  - Otherwise N64 pending -> GRANT_N64.
  - On the transition, the slot contents are copied to the mem_* registers and mem_req is set.
- GRANT_x: hold the mem_* outputs stable. On mem_ack: clear mem_req, pulse x_ack, register mem_rdata into x_rdata, go to IDLE.
- Starvation counter (4 bit):
  - N64 grant while DMA pending: +1, saturating at STARVE_LIMIT.
  - DMA grant: clear.
  - DMA not pending: clear.
- x_rdata holds its value until the next ack to the same requester. Write acks leave x_rdata unchanged.
- mem_ack received in IDLE is ignored.

## Timing
- Reset values: state IDLE, mem_req 0, mem_write 0, mem_address 0, mem_wdata 0, mem_wmask 0, n64_ack 0, dma_ack 0, n64_rdata 0, dma_rdata 0, overrun 0, both slots empty, starve_cnt 0.
- Request path, idle arbiter:
  - req pulse in cycle 0.
  - Pending set in cycle 1; grant decided in cycle 1.
  - mem_req high in cycle 2.
- Completion path:
  - mem_ack in cycle k.
  - In cycle k+1: x_ack pulse, x_rdata valid, mem_req low, state IDLE.
  - Next grant decided in cycle k+1; next mem_req earliest in cycle k+2.
- Minimum turnaround: 2 cycles of mem_req low between back-to-back transactions is not required; exactly 1 low cycle (k+1).
- Simultaneous events:
  - Both reqs in the same cycle: both slots load; N64 is granted first unless starve_cnt == STARVE_LIMIT.
  - Req from the non-granted requester arriving in the mem_ack cycle: slot loads normally and is considered at k+1 only if pending is already visible at k+1; otherwise at the next IDLE.
- Reset mid-transaction: all state clears in the next cycle. mem_req drops, no ack is issued, and the pending command is discarded; the requester must reissue after reset. memory_sdram shares the same reset.

## Structure
- Package sc64:
  - typedef enum e_arb_state {IDLE, GRANT_N64, GRANT_DMA}.
  - typedef struct mem_cmd_t {write, address, wdata, wmask}.
  - Constants ARB_ID_N64 = 0 and ARB_ID_DMA = 1 for overrun indexing.
- Sub-module n64_arb_slot: pending latch plus overrun detection, instantiated once per requester. Inputs: req, cmd, grant. Outputs: pending, cmd, overrun.
- Top level: FSM, starve counter, mem_* and rdata registers.

## Test plan
- Single N64 read at 0x0000100, memory acks 5 cycles after mem_req -> mem_req high cycles 2–6, n64_ack at cycle 7 with rdata = mem_rdata (0xA55A), dma_ack never pulses.
- Simultaneous N64 write and DMA read, STARVE_LIMIT=4 -> N64 transaction first, DMA mem_req rises 1 cycle after n64_ack, each ack pulses exactly once.
- DMA pending while N64 issues back-to-back requests, STARVE_LIMIT=2 -> grant order N64, N64, DMA, N64; starve_cnt returns to 0 after the DMA grant.
- Second n64_req pulse while the N64 slot is pending -> pulse ignored, overrun = 2'b01 sticky, only one N64 transaction reaches mem_*.
- reset_n low for 1 cycle during GRANT_DMA -> next cycle: mem_req 0, all outputs at reset values, no dma_ack; a late mem_ack is ignored.
- Write with wmask 2'b10, address 0x3FFFFFE -> mem_address 0x3FFFFFE, mem_wmask 2'b10, mem_write 1, held stable until mem_ack; n64_rdata unchanged.
